// File: rtl/banked_dp_ram_arb.sv
// Dual-port front end over NUM_BANK single-port RAM banks. Accesses to different
// banks proceed in parallel; same-bank collisions are arbitrated round-robin and counted.
module banked_dp_ram_arb #(
    parameter int WIDTH      = 8,
    parameter int ADDR_TOTAL = 10,
    parameter int NUM_BANK   = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_a,
    input  logic                  i_we_a,
    input  logic [ADDR_TOTAL-1:0] i_addr_a,
    input  logic [WIDTH-1:0]      i_din_a,
    input  logic                  i_req_b,
    input  logic                  i_we_b,
    input  logic [ADDR_TOTAL-1:0] i_addr_b,
    input  logic [WIDTH-1:0]      i_din_b,
    output logic                  o_gnt_a,
    output logic                  o_rvalid_a,
    output logic [WIDTH-1:0]      o_dout_a,
    output logic                  o_gnt_b,
    output logic                  o_rvalid_b,
    output logic [WIDTH-1:0]      o_dout_b,
    output logic [CNT_W-1:0]      o_conflict_cnt
);

    localparam int BANK_W = $clog2(NUM_BANK);
    localparam int ROW_W  = ADDR_TOTAL - BANK_W;
    localparam int DEPTH  = 1 << ROW_W;

    logic [BANK_W-1:0] bank_a_s;
    logic [BANK_W-1:0] bank_b_s;
    logic [ROW_W-1:0]  row_a_s;
    logic [ROW_W-1:0]  row_b_s;
    logic              conflict_s;
    logic              gnt_a_s;
    logic              gnt_b_s;
    logic              prio_b_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              rvalid_a_r;
    logic              rvalid_b_r;
    logic [WIDTH-1:0]  dout_a_r;
    logic [WIDTH-1:0]  dout_b_r;
    logic [WIDTH-1:0]  bank_rdata_s [NUM_BANK];

    assign bank_a_s = i_addr_a[ADDR_TOTAL-1 -: BANK_W];
    assign bank_b_s = i_addr_b[ADDR_TOTAL-1 -: BANK_W];
    assign row_a_s  = i_addr_a[ROW_W-1:0];
    assign row_b_s  = i_addr_b[ROW_W-1:0];

    // Grant arbitration: parallel on distinct banks, pointer decides on a shared bank
    always_comb begin
        conflict_s = 1'b0;
        gnt_a_s    = 1'b0;
        gnt_b_s    = 1'b0;
        if (!i_rst_n) begin
            conflict_s = 1'b0;
            gnt_a_s    = 1'b0;
            gnt_b_s    = 1'b0;
        end else begin
            conflict_s = i_req_a && i_req_b && (bank_a_s == bank_b_s);
            if (conflict_s) begin
                gnt_a_s = !prio_b_r;
                gnt_b_s = prio_b_r;
            end else begin
                gnt_a_s = i_req_a;
                gnt_b_s = i_req_b;
            end
        end
    end

    for (genvar k = 0; k < NUM_BANK; k++) begin : g_bank
        logic [WIDTH-1:0] mem_r [DEPTH];
        logic             sel_a_s;
        logic             sel_b_s;
        logic             we_s;
        logic [ROW_W-1:0] row_s;
        logic [WIDTH-1:0] wdata_s;

        // Steer this bank's single port to whichever granted requester targets it
        always_comb begin
            sel_a_s = gnt_a_s && (bank_a_s == BANK_W'(k));
            sel_b_s = gnt_b_s && (bank_b_s == BANK_W'(k));
            if (sel_a_s) begin
                row_s   = row_a_s;
                we_s    = i_we_a;
                wdata_s = i_din_a;
            end else begin
                row_s   = row_b_s;
                we_s    = sel_b_s && i_we_b;
                wdata_s = i_din_b;
            end
        end

        // Bank storage; contents deliberately survive reset
        always_ff @(posedge i_clk) begin
            if (we_s) begin
                mem_r[row_s] <= wdata_s;
            end
        end

        assign bank_rdata_s[k] = mem_r[row_s];
    end

    // Pointer, saturating conflict counter and read return registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prio_b_r   <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
            dout_a_r   <= {WIDTH{1'b0}};
            dout_b_r   <= {WIDTH{1'b0}};
        end else begin
            if (conflict_s) begin
                prio_b_r <= ~prio_b_r;
            end
            if (conflict_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            rvalid_a_r <= gnt_a_s && !i_we_a;
            rvalid_b_r <= gnt_b_s && !i_we_b;
            // Old row content is captured, so a same-edge write is not visible here
            if (gnt_a_s && !i_we_a) begin
                dout_a_r <= bank_rdata_s[bank_a_s];
            end
            if (gnt_b_s && !i_we_b) begin
                dout_b_r <= bank_rdata_s[bank_b_s];
            end
        end
    end

    // Masking with reset suppresses a pulse whose grant edge directly preceded reset
    assign o_gnt_a        = gnt_a_s;
    assign o_gnt_b        = gnt_b_s;
    assign o_rvalid_a     = rvalid_a_r && i_rst_n;
    assign o_rvalid_b     = rvalid_b_r && i_rst_n;
    assign o_dout_a       = i_rst_n ? dout_a_r : {WIDTH{1'b0}};
    assign o_dout_b       = i_rst_n ? dout_b_r : {WIDTH{1'b0}};
    assign o_conflict_cnt = cnt_r;

endmodule

// File: tb/tb_banked_dp_ram_arb.sv
// Directed bench for banked_dp_ram_arb: a reference memory/arbiter model feeds
// per-port read scoreboards; a second instance with CNT_W=4 checks saturation.
module tb_banked_dp_ram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, we_a, req_b, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [7:0]  din_a, din_b;
    logic        gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] cnt;
    logic        s_gnt_a, s_rvalid_a, s_gnt_b, s_rvalid_b;
    logic [7:0]  s_dout_a, s_dout_b;
    logic [3:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mdl [1024];
    logic [7:0]  q_a [$];
    logic [7:0]  q_b [$];
    logic        ptr_m = 1'b0;
    logic [15:0] cnt_m = 16'd0;
    logic [3:0]  cnt4_m = 4'd0;
    logic [7:0]  last_a = 8'h00;
    logic [7:0]  last_b = 8'h00;

    always #5 clk = ~clk;

    banked_dp_ram_arb u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .i_req_b(req_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_gnt_a(gnt_a), .o_rvalid_a(rvalid_a), .o_dout_a(dout_a),
        .o_gnt_b(gnt_b), .o_rvalid_b(rvalid_b), .o_dout_b(dout_b),
        .o_conflict_cnt(cnt)
    );

    banked_dp_ram_arb #(.CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .i_req_b(req_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_gnt_a(s_gnt_a), .o_rvalid_a(s_rvalid_a), .o_dout_a(s_dout_a),
        .o_gnt_b(s_gnt_b), .o_rvalid_b(s_rvalid_b), .o_dout_b(s_dout_b),
        .o_conflict_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check grants, model the edge, check outputs.
    // drop=1 asserts reset right after the edge, so any read granted there must vanish.
    task automatic step(input logic rst,
                        input logic ra, input logic wa, input logic [9:0] aa, input logic [7:0] da,
                        input logic rb, input logic wb, input logic [9:0] ab, input logic [7:0] db,
                        input logic drop);
        logic conf, ega, egb, erv_a, erv_b;
        rst_n = rst;
        req_a = ra; we_a = wa; addr_a = aa; din_a = da;
        req_b = rb; we_b = wb; addr_b = ab; din_b = db;
        conf = rst && ra && rb && (aa[9:8] == ab[9:8]);
        ega  = rst && ra && (!conf || !ptr_m);
        egb  = rst && rb && (!conf || ptr_m);
        #1;
        chk("gnt_a", gnt_a, ega);
        chk("gnt_b", gnt_b, egb);
        chk("sat_gnt_a", s_gnt_a, ega);
        @(posedge clk);
        erv_a = ega && !wa && !drop;
        erv_b = egb && !wb && !drop;
        if (erv_a) q_a.push_back(mdl[aa]);
        if (erv_b) q_b.push_back(mdl[ab]);
        if (ega && wa) mdl[aa] = da;
        if (egb && wb) mdl[ab] = db;
        if (conf) begin
            ptr_m = ~ptr_m;
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            if (cnt4_m != 4'hF) cnt4_m = cnt4_m + 4'd1;
        end
        if (!rst) begin
            ptr_m = 1'b0; cnt_m = 16'd0; cnt4_m = 4'd0;
            last_a = 8'h00; last_b = 8'h00;
        end
        if (drop) begin
            #1 rst_n = 1'b0;
            last_a = 8'h00; last_b = 8'h00;
        end
        #1;
        chk("rvalid_a", rvalid_a, erv_a);
        chk("rvalid_b", rvalid_b, erv_b);
        if (rvalid_a === 1'b1 && q_a.size() > 0) last_a = q_a.pop_front();
        if (rvalid_b === 1'b1 && q_b.size() > 0) last_b = q_b.pop_front();
        chk("dout_a", dout_a, last_a);
        chk("dout_b", dout_b, last_b);
        chk("conflict_cnt", cnt, cnt_m);
        chk("sat_conflict_cnt", s_cnt, cnt4_m);
        @(negedge clk);
    endtask

    initial begin
        // Reset, with a write request that must be neither granted nor committed
        step(1'b0, 1'b1, 1'b1, 10'h0DD, 8'h55, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        chk("reset_cnt", cnt, 16'd0);
        chk("reset_dout_a", dout_a, 8'h00);

        // Parallel writes then crossed parallel reads
        step(1'b1, 1'b1, 1'b1, 10'h0DD, 8'h1F, 1'b1, 1'b1, 10'h1FC, 8'hEB, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'h1FC, 8'h00, 1'b1, 1'b0, 10'h0DD, 8'h00, 1'b0);
        chk("par_dout_a", dout_a, 8'hEB);
        chk("par_dout_b", dout_b, 8'h1F);
        chk("par_cnt", cnt, 16'd0);
        step(1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        chk("hold_dout_a", dout_a, 8'hEB);

        // Round-robin on bank 2
        step(1'b1, 1'b1, 1'b1, 10'h223, 8'h11, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b1, 10'h2AB, 8'h22, 1'b0);
        step(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'h223, 8'h00, 1'b1, 1'b0, 10'h2AB, 8'h00, 1'b0);
        chk("rr_cnt_1", cnt, 16'd1);
        chk("rr_dout_a", dout_a, 8'h11);
        step(1'b1, 1'b1, 1'b0, 10'h223, 8'h00, 1'b1, 1'b0, 10'h2AB, 8'h00, 1'b0);
        chk("rr_dout_b", dout_b, 8'h22);
        step(1'b1, 1'b1, 1'b0, 10'h223, 8'h00, 1'b1, 1'b0, 10'h2AB, 8'h00, 1'b0);
        chk("rr_cnt_3", cnt, 16'd3);

        // Same-address conflict: A's write wins, B then reads the new value
        step(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 10'h323, 8'hDE, 1'b1, 1'b0, 10'h323, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 10'h323, 8'h00, 1'b0);
        chk("same_addr_dout_b", dout_b, 8'hDE);
        chk("same_addr_rvalid_b", rvalid_b, 1'b1);

        // Read granted just before reset is dropped; memory survives reset
        step(1'b1, 1'b1, 1'b0, 10'h0DD, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);
        chk("mid_rst_dout_a", dout_a, 8'h00);
        chk("mid_rst_cnt", cnt, 16'd0);
        step(1'b1, 1'b1, 1'b0, 10'h223, 8'h00, 1'b1, 1'b0, 10'h2AB, 8'h00, 1'b0);
        chk("post_rst_ptr_a", dout_a, 8'h11);
        step(1'b1, 1'b1, 1'b0, 10'h0DD, 8'h00, 1'b1, 1'b0, 10'h1FC, 8'h00, 1'b0);
        chk("retain_dout_a", dout_a, 8'h1F);
        chk("retain_dout_b", dout_b, 8'hEB);

        // Saturation of the 4-bit counter over 20 further conflicts
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 10'h223, 8'h00, 1'b1, 1'b0, 10'h2AB, 8'h00, 1'b0);
        end
        chk("sat_cnt4", s_cnt, 4'hF);
        chk("sat_cnt16", cnt, 16'd21);
        step(1'b1, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0);

        chk("q_a_drained", q_a.size(), 32'd0);
        chk("q_b_drained", q_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/banked_dp_ram_arb.md
BANKED_DP_RAM_ARB -- requirements
Module: banked_dp_ram_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_TOTAL, default 10, full address width; bank = i_addr_x[ADDR_TOTAL-1 -: log2(NUM_BANK)], row = remaining low bits.
REQ-003 SHALL have parameter NUM_BANK, default 4, bank count; must be a power of 2 and at least 2.
REQ-004 SHALL have parameter CNT_W, default 16, conflict counter width.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have, for x in {a,b}, port i_req_x, input, 1, access request.
REQ-008 SHALL have, for x in {a,b}, port i_we_x, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have, for x in {a,b}, port i_addr_x, input, ADDR_TOTAL, bank plus row address.
REQ-010 SHALL have, for x in {a,b}, port i_din_x, input, WIDTH, write data.
REQ-011 SHALL have, for x in {a,b}, port o_gnt_x, output, 1, combinational grant for the current-cycle request.
REQ-012 SHALL have, for x in {a,b}, port o_rvalid_x, output, 1, read data valid.
REQ-013 SHALL have, for x in {a,b}, port o_dout_x, output, WIDTH, read data.
REQ-014 SHALL have port o_conflict_cnt, output, CNT_W, saturating count of bank-conflict cycles.

Function
REQ-015 SHALL hold NUM_BANK independent single-port banks, each 2^(ADDR_TOTAL-log2(NUM_BANK)) words deep.
REQ-016 SHALL grant both ports in the same cycle when both request and the bank fields differ.
REQ-017 SHALL treat as a conflict any cycle where both ports request and the bank fields are equal; exactly one port is granted.
REQ-018 SHALL resolve conflicts round-robin with a 1-bit priority pointer, reset value A; the winner gets priority next-lowest, so the pointer moves to the other port only after a conflict.
REQ-019 SHALL leave the pointer unchanged in cycles without a conflict.
REQ-020 SHALL assert o_gnt_x only when i_req_x=1; the requester must hold i_req/i_we/i_addr/i_din stable until it samples o_gnt_x=1 at a rising edge.
REQ-021 SHALL commit a granted write to the bank on the same rising edge; writes produce no o_rvalid_x pulse.
REQ-022 SHALL give granted reads a latency of 1: o_rvalid_x=1 in the cycle after the grant edge, with o_dout_x = the row content before any write on that edge.
REQ-023 SHALL keep o_rvalid_x a single-cycle pulse per granted read; back-to-back granted reads give continuous o_rvalid_x.
REQ-024 SHALL keep o_dout_x at its last read value when no read is returning.
REQ-025 SHALL return to each port only data read on that port's own grant; data never crosses between ports.
REQ-026 SHALL increment o_conflict_cnt by 1 on each conflict cycle while i_rst_n=1, and saturate at all-ones with no wrap.
REQ-027 SHALL not reset memory contents; the bench SHALL read only locations it has already written.

Reset
REQ-028 SHALL, when i_rst_n=0 at a rising edge, set o_rvalid_a/b=0, o_dout_a/b=0, o_conflict_cnt=0 and the priority pointer to A.
REQ-029 SHALL hold o_gnt_a/b=0 while i_rst_n=0, and SHALL not commit writes during reset.
REQ-030 SHALL drop a read granted on the edge just before reset assertion: no o_rvalid_x during or after reset.
REQ-031 SHALL allow grants from the first edge with i_rst_n=1.

Verification
REQ-032 Scenario, parallel writes and reads (defaults): A writes 0x1F to 0x0DD while B writes 0xEB to 0x1FC in the same cycle -> both granted, count stays 0; next cycle A reads 0x1FC and B reads 0x0DD -> one cycle later o_rvalid_a=o_rvalid_b=1, o_dout_a=0xEB, o_dout_b=0x1F.
REQ-033 Scenario, conflict round-robin: after reset both ports read bank 2 (0x223 and 0x2AB), held for 2 cycles -> cycle 1 gnt_a=1, gnt_b=0; cycle 2 gnt_b=1; o_conflict_cnt=1 after cycle 1; a second conflict then grants A.
REQ-034 Scenario, same-address conflict: A writes 0xDE to 0x323 while B reads 0x323 with pointer=A -> A granted; B granted next cycle and o_dout_b=0xDE one cycle later.
REQ-035 Scenario, saturation: CNT_W=4, 20 consecutive conflict cycles -> o_conflict_cnt=0xF, no wrap.
REQ-036 Scenario, mid-operation reset: A read granted, then i_rst_n=0 on the next edge -> o_rvalid_a stays 0, o_dout_a=0, counter=0, pointer=A; after release, prior memory contents are still readable.
